fp_div_sqrt_unit_allocator: RTL and testbench

Tracks ownership of the FP divide/square-root units and hands them to FP issue lanes.
- Sits between the FP issue stage, which raises per-lane acquire requests, and the FP div/sqrt execution units.
- Gives each unit a per-unit lifecycle FSM, grants free units to lanes in priority order, and reclaims units whose owner is selectively flushed during recovery.
- Gives the scheduler per-lane canIssue signals, so a div/sqrt op is never issued without a unit to run on.

---
 rtl/fp_div_sqrt_unit_allocator_pkg.sv | 42 ++++
 rtl/fp_div_sqrt_unit_allocator_slot.sv | 61 ++++++
 rtl/fp_div_sqrt_unit_allocator.sv | 128 ++++++++++++
 tb/tb_fp_div_sqrt_unit_allocator.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_sqrt_unit_allocator_pkg.sv
// Shared types for the FP div/sqrt unit allocator: unit lifecycle states,
// unit index / entry types and the active-list flush range predicate.
package FPDivSqrtAllocTypes;

  localparam int FP_DIVSQRT_UNIT_NUM   = 2;
  localparam int FP_DIVSQRT_AL_PTR_W   = 6;
  localparam int FP_DIVSQRT_UNIT_IDX_W =
    (FP_DIVSQRT_UNIT_NUM > 1) ? $clog2(FP_DIVSQRT_UNIT_NUM) : 1;

  // Lifecycle of one div/sqrt unit.
  typedef enum logic [1:0] {
    FREE     = 2'd0,
    RESERVED = 2'd1,
    BUSY     = 2'd2,
    DONE     = 2'd3
  } FPDivSqrtUnitState;

  typedef logic [FP_DIVSQRT_UNIT_IDX_W-1:0] UnitIdxPath;

  typedef struct packed {
    FPDivSqrtUnitState                state;
    logic [FP_DIVSQRT_AL_PTR_W-1:0]   alPtr;
  } FPDivSqrtUnitEntry;

  // Range test on the circular active list. Pointers are zero-extended to
  // 32 bits by the caller so any pointer width up to 32 works unchanged.
  // head==tail means an empty range unless every op is being flushed.
  function automatic logic InFlushRange(
    input logic [31:0] p,
    input logic [31:0] head,
    input logic [31:0] tail,
    input logic        flushAll
  );
    logic hit;
    if (flushAll)         hit = 1'b1;
    else if (head < tail) hit = (p >= head) && (p < tail);
    else if (head > tail) hit = (p >= head) || (p < tail);
    else                  hit = 1'b0;
    return hit;
  endfunction

endpackage

// File: rtl/fp_div_sqrt_unit_allocator_slot.sv
// One div/sqrt unit: lifecycle FSM plus the active-list pointer of its owner.
// A flush hitting the owner overrides every other event on the same cycle.
module fp_div_sqrt_unit_slot
  import FPDivSqrtAllocTypes::*;
#(
  parameter int AL_PTR_W = FP_DIVSQRT_AL_PTR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reserve,
  input  logic [AL_PTR_W-1:0] reservePtr,
  input  logic                start,
  input  logic                finished,
  input  logic                rel,
  input  logic                toRecoveryPhase,
  input  logic [AL_PTR_W-1:0] flushHeadPtr,
  input  logic [AL_PTR_W-1:0] flushTailPtr,
  input  logic                flushAllInsns,
  output FPDivSqrtUnitState   state,
  output logic [AL_PTR_W-1:0] alPtr,
  output logic                busy,
  output logic                kill,
  output logic                protoErr
);

  // Owner flushed while holding the unit: abort it.
  always_comb begin
    busy = (state != FREE);
    kill = busy && toRecoveryPhase &&
           InFlushRange(32'(alPtr), 32'(flushHeadPtr), 32'(flushTailPtr), flushAllInsns);
  end

  // Lifecycle events arriving in the wrong state are dropped and flagged.
  always_comb begin
    protoErr = !kill && ((start    && (state != RESERVED)) ||
                         (finished && (state != BUSY))     ||
                         (rel      && (state != DONE)));
  end

  // Lifecycle FSM and owner register; kill returns the unit to FREE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FREE;
      alPtr <= '0;
    end else if (kill) begin
      state <= FREE;
    end else begin
      case (state)
        FREE: if (reserve) begin
          state <= RESERVED;
          alPtr <= reservePtr;
        end
        RESERVED: if (start)    state <= BUSY;
        BUSY:     if (finished) state <= DONE;
        DONE:     if (rel)      state <= FREE;
        default:                state <= FREE;
      endcase
    end
  end

endmodule

// File: rtl/fp_div_sqrt_unit_allocator.sv
// FP div/sqrt unit allocator: hands free units to issue lanes in index
// order, tracks each unit's lifecycle and reclaims units of flushed owners.
// Optional macro RSD_FP_DIVSQRT_ALLOC_PERF_EN adds saturating perf counters.
//
// Handshake: canIssue[i] is lane i's ready, acquire[i] its valid. A unit is
// taken only when both are high; canIssue/grantUnit depend on registered
// state alone, and acquire[i] without canIssue[i] is illegal, ignored and
// reported on protocolError together with misplaced start/finish/release.
module fp_div_sqrt_unit_allocator
  import FPDivSqrtAllocTypes::*;
#(
  parameter int UNIT_NUM    = FP_DIVSQRT_UNIT_NUM,
  parameter int ISSUE_WIDTH = 2,
  parameter int AL_PTR_W    = FP_DIVSQRT_AL_PTR_W,
  parameter int UNIT_IDX_W  = (UNIT_NUM > 1) ? $clog2(UNIT_NUM) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ISSUE_WIDTH-1:0]                 acquire,
  input  logic [ISSUE_WIDTH-1:0][AL_PTR_W-1:0]   acquireAlPtr,
  output logic [ISSUE_WIDTH-1:0]                 canIssue,
  output logic [ISSUE_WIDTH-1:0][UNIT_IDX_W-1:0] grantUnit,
  input  logic [UNIT_NUM-1:0]                    unitStart,
  input  logic [UNIT_NUM-1:0]                    unitFinished,
  input  logic [UNIT_NUM-1:0]                    unitRelease,
  input  logic                                   toRecoveryPhase,
  input  logic [AL_PTR_W-1:0]                    flushHeadPtr,
  input  logic [AL_PTR_W-1:0]                    flushTailPtr,
  input  logic                                   flushAllInsns,
  output logic [UNIT_NUM-1:0]                    unitBusy,
  output logic [UNIT_NUM-1:0][AL_PTR_W-1:0]      unitAlPtr,
  output logic [UNIT_NUM-1:0]                    unitKill,
  output FPDivSqrtUnitState [UNIT_NUM-1:0]       unitStateDbg,
  output logic                                   protocolError
`ifdef RSD_FP_DIVSQRT_ALLOC_PERF_EN
  ,
  output logic [31:0]                            perfStallCycles,
  output logic [31:0]                            perfAcquires,
  output logic [31:0]                            perfKills
`endif
);

  logic [31:0]                        free_cnt;
  logic [ISSUE_WIDTH-1:0]             acq_flushed;
  logic [UNIT_NUM-1:0]                reserve;
  logic [UNIT_NUM-1:0][AL_PTR_W-1:0]  reserve_ptr;
  logic [UNIT_NUM-1:0]                slot_err;

  // Lane i gets the i-th free unit by ascending index; no same-cycle bypass.
  always_comb begin
    free_cnt = 32'd0;
    for (int i = 0; i < ISSUE_WIDTH; i++) grantUnit[i] = UNIT_IDX_W'(i);
    for (int u = 0; u < UNIT_NUM; u++) begin
      if (!unitBusy[u]) begin
        for (int i = 0; i < ISSUE_WIDTH; i++)
          if (free_cnt == 32'(i)) grantUnit[i] = UNIT_IDX_W'(u);
        free_cnt = free_cnt + 32'd1;
      end
    end
    for (int i = 0; i < ISSUE_WIDTH; i++) canIssue[i] = (free_cnt > 32'(i));
  end

  // Route each accepted, unflushed acquire to the unit its lane was granted.
  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++)
      acq_flushed[i] = toRecoveryPhase &&
        InFlushRange(32'(acquireAlPtr[i]), 32'(flushHeadPtr), 32'(flushTailPtr), flushAllInsns);
    for (int u = 0; u < UNIT_NUM; u++) begin
      reserve[u]     = 1'b0;
      reserve_ptr[u] = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (acquire[i] && canIssue[i] && !acq_flushed[i] &&
            (grantUnit[i] == UNIT_IDX_W'(u))) begin
          reserve[u]     = 1'b1;
          reserve_ptr[u] = acquireAlPtr[i];
        end
      end
    end
  end

  // Any dropped illegal event this cycle.
  always_comb begin
    protocolError = (|(acquire & ~canIssue)) || (|slot_err);
  end

  for (genvar u = 0; u < UNIT_NUM; u++) begin : g_slot
    fp_div_sqrt_unit_slot #(.AL_PTR_W(AL_PTR_W)) u_slot (
      .clk             (clk),
      .rst             (rst),
      .reserve         (reserve[u]),
      .reservePtr      (reserve_ptr[u]),
      .start           (unitStart[u]),
      .finished        (unitFinished[u]),
      .rel             (unitRelease[u]),
      .toRecoveryPhase (toRecoveryPhase),
      .flushHeadPtr    (flushHeadPtr),
      .flushTailPtr    (flushTailPtr),
      .flushAllInsns   (flushAllInsns),
      .state           (unitStateDbg[u]),
      .alPtr           (unitAlPtr[u]),
      .busy            (unitBusy[u]),
      .kill            (unitKill[u]),
      .protoErr        (slot_err[u])
    );
  end

`ifdef RSD_FP_DIVSQRT_ALLOC_PERF_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Saturating counters: lane-0 stall cycles, accepted acquires, kills.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perfStallCycles <= '0;
      perfAcquires    <= '0;
      perfKills       <= '0;
    end else begin
      perfStallCycles <= sat_add(perfStallCycles, {31'd0, !canIssue[0]});
      perfAcquires    <= sat_add(perfAcquires, 32'($countones(reserve)));
      perfKills       <= sat_add(perfKills, 32'($countones(unitKill)));
    end
  end
`endif

endmodule

// File: tb/tb_fp_div_sqrt_unit_allocator.sv
// Directed bench for fp_div_sqrt_unit_allocator (UNIT_NUM=2, ISSUE_WIDTH=2).
module tb_fp_div_sqrt_unit_allocator;
  import FPDivSqrtAllocTypes::*;

  logic             clk;
  logic             rst;
  logic [1:0]       acquire;
  logic [1:0][5:0]  acq_ptr;
  logic [1:0]       can_issue;
  logic [1:0]       grant_unit;
  logic [1:0]       unit_start;
  logic [1:0]       unit_finished;
  logic [1:0]       unit_release;
  logic             recovery;
  logic [5:0]       flush_head;
  logic [5:0]       flush_tail;
  logic             flush_all;
  logic [1:0]       unit_busy;
  logic [1:0][5:0]  unit_al_ptr;
  logic [1:0]       unit_kill;
  FPDivSqrtUnitState [1:0] unit_state;
  logic             proto_err;
`ifdef RSD_FP_DIVSQRT_ALLOC_PERF_EN
  logic [31:0]      perf_stall;
  logic [31:0]      perf_acq;
  logic [31:0]      perf_kill;
`endif

  int checks = 0;
  int errors = 0;

  fp_div_sqrt_unit_allocator #(
    .UNIT_NUM(2), .ISSUE_WIDTH(2), .AL_PTR_W(6)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .acquire         (acquire),
    .acquireAlPtr    (acq_ptr),
    .canIssue        (can_issue),
    .grantUnit       (grant_unit),
    .unitStart       (unit_start),
    .unitFinished    (unit_finished),
    .unitRelease     (unit_release),
    .toRecoveryPhase (recovery),
    .flushHeadPtr    (flush_head),
    .flushTailPtr    (flush_tail),
    .flushAllInsns   (flush_all),
    .unitBusy        (unit_busy),
    .unitAlPtr       (unit_al_ptr),
    .unitKill        (unit_kill),
    .unitStateDbg    (unit_state),
    .protocolError   (proto_err)
`ifdef RSD_FP_DIVSQRT_ALLOC_PERF_EN
    ,
    .perfStallCycles (perf_stall),
    .perfAcquires    (perf_acq),
    .perfKills       (perf_kill)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    acquire       = 2'b00;
    acq_ptr       = '0;
    unit_start    = 2'b00;
    unit_finished = 2'b00;
    unit_release  = 2'b00;
    recovery      = 1'b0;
    flush_head    = '0;
    flush_tail    = '0;
    flush_all     = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    cycle();
  endtask

  task automatic acquire_two(input logic [5:0] p0, input logic [5:0] p1);
    acquire    = 2'b11;
    acq_ptr[0] = p0;
    acq_ptr[1] = p1;
    cycle();
    idle();
  endtask

  task automatic set_flush(input logic rec, input logic [5:0] h, input logic [5:0] t, input logic all);
    recovery   = rec;
    flush_head = h;
    flush_tail = t;
    flush_all  = all;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    #3;
    checks++;
    if (unit_busy !== 2'b00) begin errors++; $display("FAIL reset_busy got=%b exp=00", unit_busy); end
    rst = 1'b1;
    cycle();
    checks++;
    if (can_issue !== 2'b11) begin errors++; $display("FAIL reset_can_issue got=%b exp=11", can_issue); end
    checks++;
    if (grant_unit !== 2'b10) begin errors++; $display("FAIL reset_grant got=%b exp=10", grant_unit); end
    checks++;
    if (unit_kill !== 2'b00) begin errors++; $display("FAIL reset_kill got=%b exp=00", unit_kill); end
    checks++;
    if (unit_al_ptr !== 12'd0) begin errors++; $display("FAIL reset_alptr got=%h exp=0", unit_al_ptr); end
`ifdef RSD_FP_DIVSQRT_ALLOC_PERF_EN
    checks++;
    if ({perf_stall, perf_acq, perf_kill} !== 96'd0) begin
      errors++; $display("FAIL reset_perf got=%0d/%0d/%0d exp=0/0/0", perf_stall, perf_acq, perf_kill);
    end
`endif
  endtask

  task automatic test_acquire();
    acquire    = 2'b11;
    acq_ptr[0] = 6'd5;
    acq_ptr[1] = 6'd6;
    #1;
    checks++;
    if (grant_unit !== 2'b10) begin errors++; $display("FAIL acq_grant got=%b exp=10", grant_unit); end
    cycle();
    idle();
    checks++;
    if (unit_busy !== 2'b11) begin errors++; $display("FAIL acq_busy got=%b exp=11", unit_busy); end
    checks++;
    if (can_issue !== 2'b00) begin errors++; $display("FAIL acq_can_issue got=%b exp=00", can_issue); end
    checks++;
    if (unit_al_ptr[0] !== 6'd5 || unit_al_ptr[1] !== 6'd6) begin
      errors++; $display("FAIL acq_alptr got=%0d,%0d exp=5,6", unit_al_ptr[0], unit_al_ptr[1]);
    end
    checks++;
    if (unit_state[0] !== RESERVED) begin errors++; $display("FAIL acq_state got=%0d exp=%0d", unit_state[0], RESERVED); end
  endtask

  task automatic test_lifecycle();
    unit_start = 2'b01;
    #1;
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL life_start_err got=%b exp=0", proto_err); end
    cycle();
    idle();
    checks++;
    if (unit_state[0] !== BUSY) begin errors++; $display("FAIL life_busy got=%0d exp=%0d", unit_state[0], BUSY); end
    unit_finished = 2'b01;
    cycle();
    idle();
    checks++;
    if (unit_state[0] !== DONE) begin errors++; $display("FAIL life_done got=%0d exp=%0d", unit_state[0], DONE); end
    unit_finished = 2'b10;
    #1;
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL life_bad_finish_err got=%b exp=1", proto_err); end
    cycle();
    idle();
    checks++;
    if (unit_state[1] !== RESERVED) begin errors++; $display("FAIL life_bad_finish_state got=%0d exp=%0d", unit_state[1], RESERVED); end
    unit_release = 2'b01;
    #1;
    checks++;
    if (can_issue !== 2'b00) begin errors++; $display("FAIL life_no_bypass got=%b exp=00", can_issue); end
    cycle();
    idle();
    checks++;
    if (unit_state[0] !== FREE) begin errors++; $display("FAIL life_free got=%0d exp=%0d", unit_state[0], FREE); end
    checks++;
    if (can_issue !== 2'b01 || grant_unit[0] !== 1'b0) begin
      errors++; $display("FAIL life_reissue got=%b/%b exp=01/0", can_issue, grant_unit[0]);
    end
  endtask

  task automatic test_wrap_flush();
    do_reset();
    acquire_two(6'd62, 6'd2);
    set_flush(1'b0, 6'd0, 6'd0, 1'b1);
    checks++;
    if (unit_kill !== 2'b00) begin errors++; $display("FAIL wrap_no_recovery got=%b exp=00", unit_kill); end
    set_flush(1'b1, 6'd3, 6'd60, 1'b0);
    checks++;
    if (unit_kill !== 2'b00) begin errors++; $display("FAIL wrap_outside got=%b exp=00", unit_kill); end
    set_flush(1'b1, 6'd2, 6'd2, 1'b0);
    checks++;
    if (unit_kill !== 2'b00) begin errors++; $display("FAIL wrap_empty got=%b exp=00", unit_kill); end
    set_flush(1'b1, 6'd60, 6'd3, 1'b0);
    checks++;
    if (unit_kill !== 2'b11) begin errors++; $display("FAIL wrap_kill got=%b exp=11", unit_kill); end
    cycle();
    idle();
    checks++;
    if (unit_busy !== 2'b00 || can_issue !== 2'b11) begin
      errors++; $display("FAIL wrap_freed got=%b/%b exp=00/11", unit_busy, can_issue);
    end
  endtask

  task automatic test_kill_vs_finish();
    acquire_two(6'd20, 6'd10);
    unit_start = 2'b11;
    cycle();
    idle();
    checks++;
    if (unit_state[0] !== BUSY || unit_state[1] !== BUSY) begin
      errors++; $display("FAIL kvf_busy got=%0d,%0d exp=%0d,%0d", unit_state[0], unit_state[1], BUSY, BUSY);
    end
    unit_finished = 2'b11;
    set_flush(1'b1, 6'd8, 6'd12, 1'b0);
    checks++;
    if (unit_kill !== 2'b10) begin errors++; $display("FAIL kvf_kill got=%b exp=10", unit_kill); end
    cycle();
    idle();
    checks++;
    if (unit_state[1] !== FREE || unit_state[0] !== DONE) begin
      errors++; $display("FAIL kvf_states got=%0d,%0d exp=%0d,%0d", unit_state[1], unit_state[0], FREE, DONE);
    end
    set_flush(1'b1, 6'd21, 6'd30, 1'b0);
    checks++;
    if (unit_kill !== 2'b00) begin errors++; $display("FAIL kvf_below_head got=%b exp=00", unit_kill); end
    set_flush(1'b1, 6'd10, 6'd20, 1'b0);
    checks++;
    if (unit_kill !== 2'b00) begin errors++; $display("FAIL kvf_tail_excl got=%b exp=00", unit_kill); end
    set_flush(1'b1, 6'd20, 6'd21, 1'b0);
    checks++;
    if (unit_kill !== 2'b01) begin errors++; $display("FAIL kvf_head_incl got=%b exp=01", unit_kill); end
    cycle();
    idle();
    checks++;
    if (unit_busy !== 2'b00) begin errors++; $display("FAIL kvf_all_free got=%b exp=00", unit_busy); end
  endtask

  task automatic test_illegal_acquire();
    acquire    = 2'b01;
    acq_ptr[0] = 6'd30;
    cycle();
    idle();
    checks++;
    if (can_issue !== 2'b01 || grant_unit[0] !== 1'b1) begin
      errors++; $display("FAIL ill_one_free got=%b/%b exp=01/1", can_issue, grant_unit[0]);
    end
    acquire    = 2'b10;
    acq_ptr[1] = 6'd40;
    #1;
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL ill_err got=%b exp=1", proto_err); end
    cycle();
    idle();
    checks++;
    if (unit_busy !== 2'b01 || unit_state[1] !== FREE) begin
      errors++; $display("FAIL ill_ignored got=%b/%0d exp=01/%0d", unit_busy, unit_state[1], FREE);
    end
    acquire    = 2'b01;
    acq_ptr[0] = 6'd45;
    set_flush(1'b1, 6'd40, 6'd50, 1'b0);
    checks++;
    if (unit_kill !== 2'b00 || proto_err !== 1'b0) begin
      errors++; $display("FAIL ill_flush_acq_comb got=%b/%b exp=00/0", unit_kill, proto_err);
    end
    cycle();
    idle();
    checks++;
    if (unit_busy !== 2'b01) begin errors++; $display("FAIL ill_flush_acq got=%b exp=01", unit_busy); end
  endtask

  task automatic test_async_reset();
    acquire    = 2'b01;
    acq_ptr[0] = 6'd7;
    cycle();
    idle();
    unit_start = 2'b11;
    cycle();
    idle();
    checks++;
    if (unit_state[0] !== BUSY || unit_state[1] !== BUSY) begin
      errors++; $display("FAIL ares_pre got=%0d,%0d exp=%0d,%0d", unit_state[0], unit_state[1], BUSY, BUSY);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (unit_busy !== 2'b00 || unit_kill !== 2'b00) begin
      errors++; $display("FAIL ares_clear got=%b/%b exp=00/00", unit_busy, unit_kill);
    end
    checks++;
    if (can_issue !== 2'b11) begin errors++; $display("FAIL ares_can_issue got=%b exp=11", can_issue); end
`ifdef RSD_FP_DIVSQRT_ALLOC_PERF_EN
    checks++;
    if ({perf_stall, perf_acq, perf_kill} !== 96'd0) begin
      errors++; $display("FAIL ares_perf got=%0d/%0d/%0d exp=0/0/0", perf_stall, perf_acq, perf_kill);
    end
`endif
    rst = 1'b1;
    cycle();
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_acquire();
    test_lifecycle();
    test_wrap_flush();
    test_kill_vs_finish();
    test_illegal_acquire();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
